led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LED_W, default 8, pattern/LED width; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 24, prescale counter width.
REQ-003 Parameter INIT, default {LED_W-1{1'b1},1'b0} (8'hFE at default width), pattern reset value; LEDs are active-low.
REQ-004 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 Port rstn  in  1  synchronous, active-low reset.
REQ-006 Port en  in  1  advance enable; low freezes counter, step and pattern.
REQ-007 Port div  in  CNT_W  step period minus one, in clk cycles.
REQ-008 Port mode  in  2  0=rotate-left, 1=rotate-right, 2=bounce, 3=hold.
REQ-009 Port load  in  1  single-cycle request to load load_val.
REQ-010 Port load_val  in  LED_W  pattern to load.
REQ-011 Port led  out  LED_W  current pattern register.
REQ-012 Port gpio  out  CNT_W  prescale counter value.
REQ-013 Port step  out  1  registered one-cycle pulse; the pattern advances on the edge that ends a step-high cycle.

Function
REQ-014 Counter: when en=1 and count!=div, count<=count+1; when en=1 and count==div, count<=0 and step<=1; otherwise step<=0.
REQ-015 div=0: count stays 0 and step is high every enabled cycle after the first.
REQ-016 div changed mid-count: the compare uses the live value; if count>div, count SHALL wrap through 2^CNT_W-1 to 0 (no early match).
REQ-017 en=0: count, pos, dir and the pattern hold; step<=0 (a pending step is dropped).
REQ-018 On a cycle with step=1 and en=1, the pattern updates per mode (sampled that cycle); mode changes take effect at the next step only.
REQ-019 Rotate-left: led<={led[LED_W-2:0],led[LED_W-1]}; pos<=(pos==LED_W-1)?0:pos+1.
REQ-020 Rotate-right: led<={led[0],led[LED_W-1:1]}; pos<=(pos==0)?LED_W-1:pos-1.
REQ-021 Bounce, dir=L: if pos==LED_W-1, then dir<=R, rotate right, pos<=pos-1; else rotate left, pos+1.
REQ-022 Bounce, dir=R: if pos==0, then dir<=L, rotate left, pos<=1; else rotate right, pos-1.
REQ-023 Hold: led, pos and dir unchanged; the counter keeps running.
REQ-024 pos is an internal clog2(LED_W)-bit register; dir is a 1-bit register with L=0.
REQ-025 load=1 (regardless of en): led<=load_val, pos<=0, dir<=L, count<=0, step<=0; load has priority over a simultaneous step.
REQ-026 gpio=count and led=pattern register, both driven directly from flops with no combinational path from any input.

Reset
REQ-027 rstn=0 at a clk edge: count<=0, step<=0, led<=INIT, pos<=0, dir<=L; reset overrides load and en.
REQ-028 Reset asserted mid-step: no pattern update occurs on that edge; the sequence restarts from REQ-027 values.

Structure
REQ-029 Package led_pattern_pkg SHALL hold the mode encodings (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_HOLD) and the dir encodings.
REQ-030 Sub-module step_prescaler (clk, rstn, en, clr, div -> count, step) SHALL implement REQ-014..017; clr is driven by load.

Verification (LED_W=8, CNT_W=24, INIT=8'hFE)
REQ-031 Rotate-left, div=3, en=1, release reset: led=FE until the 5th edge, then FD; thereafter FB, F7, ... one step per 4 clks; 7F -> FE wraps.
REQ-032 Rotate-right, div=0: led sequence FE, 7F, BF, DF, one change per clk after the first.
REQ-033 Bounce, div=0: FE, FD, FB, F7, EF, DF, BF, 7F, BF, DF ... FE, FD (reverses at both ends, no repeat of the end value).
REQ-034 en=0 for 10 clks mid-run: gpio, led and step frozen (step=0); resume continues from the frozen count.
REQ-035 load=1 with load_val=8'h0F on the same cycle as step=1: led=0F, count=0, step=0 next cycle; next step gives 1E (rotate-left).
REQ-036 rstn=0 for 1 clk mid-bounce with dir=R: led=FE, gpio=0, step=0 after the edge; the bounce restarts leftwards.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: step modes and bounce direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_e;

endpackage

// File: rtl/step_prescaler.sv
// Free-running prescale counter that emits a registered one-cycle step pulse
// every div+1 enabled cycles; clr restarts the period and cancels a pending step.
module step_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             step
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             step_q, step_d;

  // Equality against the live div: a count already past div simply keeps
  // counting and wraps through zero instead of matching early.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == div) begin
        count_d = '0;
        step_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Active-low LED pattern generator: rotates or bounces a pattern register once
// per prescaler step, with a synchronous load that restarts the sequence.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int               LED_W = 8,
  parameter int               CNT_W = 24,
  parameter logic [LED_W-1:0] INIT  = {{(LED_W-1){1'b1}}, 1'b0}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [LED_W-1:0] load_val,
  output logic [LED_W-1:0] led,
  output logic [CNT_W-1:0] gpio,
  output logic             step
);

  localparam int               POS_W   = (LED_W > 2) ? $clog2(LED_W) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [LED_W-1:0] led_q, led_d;
  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic             step_w;
  logic [CNT_W-1:0] count_w;

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  function automatic logic [LED_W-1:0] rotr(input logic [LED_W-1:0] v);
    return {v[0], v[LED_W-1:1]};
  endfunction

  step_prescaler #(
    .CNT_W(CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (load),
    .div  (div),
    .count(count_w),
    .step (step_w)
  );

  // Load wins over a coincident step; otherwise the mode sampled on the
  // step-high cycle decides how the pattern moves on the closing edge.
  always_comb begin
    led_d = led_q;
    pos_d = pos_q;
    dir_d = dir_q;
    if (load) begin
      led_d = load_val;
      pos_d = '0;
      dir_d = DIR_L;
    end else if (en && step_w) begin
      case (mode_e'(mode))
        MODE_ROL: begin
          led_d = rotl(led_q);
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
        end
        MODE_ROR: begin
          led_d = rotr(led_q);
          pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_L) begin
            if (pos_q == POS_MAX) begin
              dir_d = DIR_R;
              led_d = rotr(led_q);
              pos_d = pos_q - POS_ONE;
            end else begin
              led_d = rotl(led_q);
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_L;
              led_d = rotl(led_q);
              pos_d = POS_ONE;
            end else begin
              led_d = rotr(led_q);
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      led_q <= INIT;
      pos_q <= '0;
      dir_q <= DIR_L;
    end else begin
      led_q <= led_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign led  = led_q;
  assign gpio = count_w;
  assign step = step_w;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops
// and compares them one cycle at a time.
module tb_led_pattern_gen;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [23:0] div;
  logic [1:0]  mode;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  led;
  logic [23:0] gpio;
  logic        step;

  typedef struct {
    logic [7:0]  led;
    logic [23:0] gpio;
    logic        step;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0] rolSeq    [0:8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [7:0] rorSeq    [0:8]  = '{8'hFE, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] bounceSeq [0:16] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                                   8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD, 8'hFB};

  led_pattern_gen #(
    .LED_W(8),
    .CNT_W(24),
    .INIT (8'hFE)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .div     (div),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .led     (led),
    .gpio    (gpio),
    .step    (step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rstnV, input logic enV, input logic [23:0] divV,
                               input logic [1:0] modeV, input logic loadV, input logic [7:0] lvV,
                               input logic [7:0] eLed, input logic [23:0] eGpio,
                               input logic eStep, input int tag);
    exp_t e;
    @(negedge clk);
    rstn     = rstnV;
    en       = enV;
    div      = divV;
    mode     = modeV;
    load     = loadV;
    load_val = lvV;
    e.led  = eLed;
    e.gpio = eGpio;
    e.step = eStep;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (led !== e.led) begin
      mismatched++;
      $display("[TB] FAIL led tag=%0d t=%0t got=%h want=%h", e.tag, $time, led, e.led);
    end
    compared++;
    if (gpio !== e.gpio) begin
      mismatched++;
      $display("[TB] FAIL gpio tag=%0d t=%0t got=%0d want=%0d", e.tag, $time, gpio, e.gpio);
    end
    compared++;
    if (step !== e.step) begin
      mismatched++;
      $display("[TB] FAIL step tag=%0d t=%0t got=%b want=%b", e.tag, $time, step, e.step);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    int waitCycles;
    rstn = 1'b0; en = 1'b0; div = '0; mode = 2'd0; load = 1'b0; load_val = '0;

    // Reset, then rotate-left with div=3: one step per 4 clocks
    applyStimulus(1'b0, 1'b1, 24'd3, 2'd0, 1'b0, 8'h00, 8'hFE, 24'd0, 1'b0, 1);
    for (int k = 1; k <= 34; k++)
      applyStimulus(1'b1, 1'b1, 24'd3, 2'd0, 1'b0, 8'h00,
                    rolSeq[(k-1)/4], 24'(k % 4), (k % 4 == 0), 2);

    // Freeze with en=0, then resume from the held count
    repeat (10) applyStimulus(1'b1, 1'b0, 24'd3, 2'd0, 1'b0, 8'h00, 8'hFE, 24'd2, 1'b0, 3);
    for (int j = 1; j <= 6; j++)
      applyStimulus(1'b1, 1'b1, 24'd3, 2'd0, 1'b0, 8'h00,
                    (j >= 3) ? 8'hFD : 8'hFE, 24'((2 + j) % 4), ((2 + j) % 4 == 0), 4);

    // Load on a step-high cycle beats the step
    applyStimulus(1'b1, 1'b1, 24'd3, 2'd0, 1'b1, 8'h0F, 8'h0F, 24'd0, 1'b0, 5);
    for (int m = 1; m <= 5; m++)
      applyStimulus(1'b1, 1'b1, 24'd3, 2'd0, 1'b0, 8'h00,
                    (m == 5) ? 8'h1E : 8'h0F, 24'(m % 4), (m % 4 == 0), 6);

    // Reset overrides a simultaneous load; then rotate-right with div=0, then hold
    applyStimulus(1'b0, 1'b1, 24'd0, 2'd1, 1'b1, 8'h0F, 8'hFE, 24'd0, 1'b0, 7);
    for (int k = 1; k <= 9; k++)
      applyStimulus(1'b1, 1'b1, 24'd0, 2'd1, 1'b0, 8'h00, rorSeq[k-1], 24'd0, 1'b1, 8);
    repeat (3) applyStimulus(1'b1, 1'b1, 24'd0, 2'd3, 1'b0, 8'h00, 8'hFE, 24'd0, 1'b1, 9);

    // Full bounce across both ends
    applyStimulus(1'b0, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, 8'hFE, 24'd0, 1'b0, 10);
    for (int k = 1; k <= 17; k++)
      applyStimulus(1'b1, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, bounceSeq[k-1], 24'd0, 1'b1, 11);

    // Reset mid-bounce while heading right; sequence restarts leftwards
    applyStimulus(1'b0, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, 8'hFE, 24'd0, 1'b0, 12);
    for (int k = 1; k <= 11; k++)
      applyStimulus(1'b1, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, bounceSeq[k-1], 24'd0, 1'b1, 13);
    applyStimulus(1'b0, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, 8'hFE, 24'd0, 1'b0, 14);
    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b1, 1'b1, 24'd0, 2'd2, 1'b0, 8'h00, bounceSeq[k-1], 24'd0, 1'b1, 15);

    waitCycles = 0;
    while (sbq.size() > 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (sbq.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain remaining=%0d want=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
